stack_op_sequencer: RTL and testbench

//  Command-side initiator for register_stack: accepts stack instructions on a valid/ready

---
 rtl/stack_op_sequencer_if.sv | 28 ++
 rtl/stack_op_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/stack_op_sequencer_if.sv
// Command/stack bus for stack_op_sequencer.
// master : instruction-decoder / stack environment side (drives commands, returns a/b)
// slave  : the sequencer itself (accepts commands, drives stackOP/w and status)
interface stack_op_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       stackOP;
  logic [WIDTH-1:0] w;
  logic [6:0]       depth;
  logic             err_under;
  logic             err_over;

  modport master (
    output cmd_valid, cmd_op, cmd_data, a, b,
    input  cmd_ready, stackOP, w, depth, err_under, err_over
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, a, b,
    output cmd_ready, stackOP, w, depth, err_under, err_over
  );
endinterface

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: command-side initiator for register_stack.
// Accepts stack instructions on a valid/ready port, reads the top two entries
// (a, b) and drives stackOP/w. ROT is expanded into six primitive ops
// (pop, pop, pop, push, push, push). Tracks the live entry count in depth.
// Optional feature macro: STACK_SEQ_GUARD_EN
//   defined   : underflow/overflow commands are consumed but issue stackOP=0 and
//               pulse err_under/err_over for one cycle, depth unchanged.
//   undefined : every command executes as issued, err_* stay 0, depth saturates.
// All outputs are registered; the stack itself updates on the negedge between.
module stack_op_sequencer #(
  parameter int STACK_DEPTH = 64,
  parameter int WIDTH       = 16
) (
  input logic                  CLK,
  input logic                  reset,
  stack_op_sequencer_if.slave  bus
);

  // Command opcodes
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_ROT  = 3'd7;

  // Primitive register_stack operations (pop-2 encoding 4 is never issued)
  localparam logic [2:0] SOP_HOLD    = 3'd0;
  localparam logic [2:0] SOP_PUSH    = 3'd1;
  localparam logic [2:0] SOP_POPREP  = 3'd2;
  localparam logic [2:0] SOP_POP     = 3'd3;
  localparam logic [2:0] SOP_SWAP    = 3'd5;

  localparam logic [6:0] DEPTH_MAX = 7'(STACK_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_R0   = 3'd1,
    ST_R1   = 3'd2,
    ST_R2   = 3'd3,
    ST_R3   = 3'd4,
    ST_R4   = 3'd5,
    ST_R5   = 3'd6
  } state_t;

  state_t           state_r;
  logic [2:0]       stack_op_r;
  logic [WIDTH-1:0] w_r;
  logic [6:0]       depth_r;
  logic             cmd_ready_r;
  logic             err_under_r;
  logic             err_over_r;
  logic [WIDTH-1:0] t0_r;
  logic [WIDTH-1:0] t1_r;
  logic [WIDTH-1:0] t2_r;

  logic             accept_s;
  logic [2:0]       dec_op_s;
  logic [WIDTH-1:0] dec_w_s;
  logic             grow_s;
  logic             shrink_s;
  logic [6:0]       depth_next_s;
  logic             rej_under_s;
  logic             rej_over_s;

`ifdef STACK_SEQ_GUARD_EN
  // Minimum live entries an opcode consumes before it can run
  function automatic logic [6:0] need_entries(input logic [2:0] op);
    logic [6:0] n;
    case (op)
      OP_DROP, OP_DUP:         n = 7'd1;
      OP_SWAP, OP_ADD, OP_SUB: n = 7'd2;
      OP_ROT:                  n = 7'd3;
      default:                 n = 7'd0;
    endcase
    return n;
  endfunction
`endif

  assign accept_s = bus.cmd_valid & cmd_ready_r;

  // Decode a single-cycle command into its primitive op, write data and depth effect
  always_comb begin
    dec_op_s = SOP_HOLD;
    dec_w_s  = '0;
    grow_s   = 1'b0;
    shrink_s = 1'b0;
    case (bus.cmd_op)
      OP_PUSH: begin
        dec_op_s = SOP_PUSH;
        dec_w_s  = bus.cmd_data;
        grow_s   = 1'b1;
      end
      OP_DROP: begin
        dec_op_s = SOP_POP;
        shrink_s = 1'b1;
      end
      OP_DUP: begin
        dec_op_s = SOP_PUSH;
        dec_w_s  = bus.a;
        grow_s   = 1'b1;
      end
      OP_SWAP: begin
        dec_op_s = SOP_SWAP;
      end
      OP_ADD: begin
        dec_op_s = SOP_POPREP;
        dec_w_s  = bus.a + bus.b;
        shrink_s = 1'b1;
      end
      OP_SUB: begin
        dec_op_s = SOP_POPREP;
        dec_w_s  = bus.b - bus.a;
        shrink_s = 1'b1;
      end
      OP_NOP, OP_ROT: begin
        dec_op_s = SOP_HOLD;
      end
      default: begin
        dec_op_s = SOP_HOLD;
      end
    endcase
  end

  // Saturating next depth for a single-cycle command
  always_comb begin
    depth_next_s = depth_r;
    if (grow_s) begin
      if (depth_r == DEPTH_MAX) begin
        depth_next_s = DEPTH_MAX;
      end else begin
        depth_next_s = depth_r + 7'd1;
      end
    end else if (shrink_s) begin
      if (depth_r == 7'd0) begin
        depth_next_s = 7'd0;
      end else begin
        depth_next_s = depth_r - 7'd1;
      end
    end else begin
      depth_next_s = depth_r;
    end
  end

  // Underflow/overflow rejection: only active when the guard is built in
  always_comb begin
`ifdef STACK_SEQ_GUARD_EN
    rej_under_s = (depth_r < need_entries(bus.cmd_op));
    rej_over_s  = grow_s && (depth_r == DEPTH_MAX);
`else
    rej_under_s = 1'b0;
    rej_over_s  = 1'b0;
`endif
  end

  // Sequencer FSM with registered stack command, handshake and status outputs
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      stack_op_r  <= SOP_HOLD;
      w_r         <= '0;
      depth_r     <= 7'd0;
      cmd_ready_r <= 1'b1;
      err_under_r <= 1'b0;
      err_over_r  <= 1'b0;
      t0_r        <= '0;
      t1_r        <= '0;
      t2_r        <= '0;
    end else begin
      err_under_r <= 1'b0;
      err_over_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (rej_under_s) begin
              stack_op_r  <= SOP_HOLD;
              w_r         <= '0;
              err_under_r <= 1'b1;
            end else if (rej_over_s) begin
              stack_op_r <= SOP_HOLD;
              w_r        <= '0;
              err_over_r <= 1'b1;
            end else if (bus.cmd_op == OP_ROT) begin
              // First pop goes out now; x is captured before it leaves the stack
              state_r     <= ST_R0;
              stack_op_r  <= SOP_POP;
              w_r         <= '0;
              t0_r        <= bus.a;
              cmd_ready_r <= 1'b0;
            end else begin
              stack_op_r <= dec_op_s;
              w_r        <= dec_w_s;
              depth_r    <= depth_next_s;
            end
          end else begin
            stack_op_r <= SOP_HOLD;
            w_r        <= '0;
          end
        end
        ST_R0: begin
          state_r    <= ST_R1;
          stack_op_r <= SOP_POP;
          t1_r       <= bus.a;
        end
        ST_R1: begin
          state_r    <= ST_R2;
          stack_op_r <= SOP_POP;
          t2_r       <= bus.a;
        end
        ST_R2: begin
          state_r    <= ST_R3;
          stack_op_r <= SOP_PUSH;
          w_r        <= t1_r;
        end
        ST_R3: begin
          state_r    <= ST_R4;
          stack_op_r <= SOP_PUSH;
          w_r        <= t0_r;
        end
        ST_R4: begin
          state_r    <= ST_R5;
          stack_op_r <= SOP_PUSH;
          w_r        <= t2_r;
        end
        ST_R5: begin
          state_r     <= ST_IDLE;
          stack_op_r  <= SOP_HOLD;
          w_r         <= '0;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          stack_op_r  <= SOP_HOLD;
          w_r         <= '0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.stackOP   = stack_op_r;
  assign bus.w         = w_r;
  assign bus.depth     = depth_r;
  assign bus.err_under = err_under_r;
  assign bus.err_over  = err_over_r;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Self-checking bench for stack_op_sequencer with a behavioural register_stack
// model that applies stackOP/w on the negedge and feeds a/b back.
module tb_stack_op_sequencer;

  logic CLK = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  stack_op_sequencer_if #(.WIDTH(16)) bus ();

  stack_op_sequencer #(.STACK_DEPTH(64), .WIDTH(16)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural register_stack: 64 entries, updates on negedge
  logic [15:0] stk [0:63] = '{default: 16'h0000};

  always @(negedge CLK) begin
    case (bus.stackOP)
      3'd1: begin
        for (int i = 63; i > 0; i--) stk[i] <= stk[i-1];
        stk[0] <= bus.w;
      end
      3'd2: begin
        stk[0] <= bus.w;
        for (int i = 1; i < 63; i++) stk[i] <= stk[i+1];
        stk[63] <= 16'h0000;
      end
      3'd3: begin
        for (int i = 0; i < 63; i++) stk[i] <= stk[i+1];
        stk[63] <= 16'h0000;
      end
      3'd5: begin
        stk[0] <= stk[1];
        stk[1] <= stk[0];
      end
      default: ;
    endcase
  end

  assign bus.a = stk[0];
  assign bus.b = stk[1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one command from a negedge, hold until accepted, return #1 after that posedge
  task automatic do_cmd(input logic [2:0] op, input logic [15:0] data);
    int waitc;
    waitc = 0;
    @(negedge CLK);
    while (!bus.cmd_ready && waitc < 50) begin
      @(negedge CLK);
      waitc++;
    end
    if (!bus.cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_ready_timeout: got 0 expected 1");
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge CLK);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    logic [2:0]  exp_sop;
    logic        chk_w;
    logic [15:0] exp_w;
    logic [6:0]  exp_depth;
    logic [15:0] exp_top;
  } vec_t;

  vec_t        vecs [14];
  logic [2:0]  rot_ops [6];
  logic [15:0] rot_w   [6];
  int          low_cnt;
  int          acc;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 16'h0000;

    //            op    data       sop   chk_w  w          depth  top
    vecs[0]  = '{3'd1, 16'd5,     3'd1, 1'b1, 16'd5,     7'd1, 16'd5};     // PUSH 5
    vecs[1]  = '{3'd1, 16'd7,     3'd1, 1'b1, 16'd7,     7'd2, 16'd7};     // PUSH 7
    vecs[2]  = '{3'd5, 16'd0,     3'd2, 1'b1, 16'd12,    7'd1, 16'd12};    // ADD
    vecs[3]  = '{3'd1, 16'd10,    3'd1, 1'b1, 16'd10,    7'd2, 16'd10};    // PUSH 10
    vecs[4]  = '{3'd1, 16'd3,     3'd1, 1'b1, 16'd3,     7'd3, 16'd3};     // PUSH 3
    vecs[5]  = '{3'd6, 16'd0,     3'd2, 1'b1, 16'd7,     7'd2, 16'd7};     // SUB b-a
    vecs[6]  = '{3'd4, 16'd0,     3'd5, 1'b0, 16'd0,     7'd2, 16'd12};    // SWAP
    vecs[7]  = '{3'd2, 16'd0,     3'd3, 1'b0, 16'd0,     7'd1, 16'd7};     // DROP
    vecs[8]  = '{3'd0, 16'd0,     3'd0, 1'b0, 16'd0,     7'd1, 16'd7};     // NOP
    vecs[9]  = '{3'd1, 16'hFFFF,  3'd1, 1'b1, 16'hFFFF,  7'd2, 16'hFFFF};  // PUSH FFFF
    vecs[10] = '{3'd3, 16'd0,     3'd1, 1'b1, 16'hFFFF,  7'd3, 16'hFFFF};  // DUP
    vecs[11] = '{3'd5, 16'd0,     3'd2, 1'b1, 16'hFFFE,  7'd2, 16'hFFFE};  // ADD wraps
    vecs[12] = '{3'd2, 16'd0,     3'd3, 1'b0, 16'd0,     7'd1, 16'd7};     // DROP
    vecs[13] = '{3'd2, 16'd0,     3'd3, 1'b0, 16'd0,     7'd0, 16'd0};     // DROP

    rot_ops = '{3'd3, 3'd3, 3'd3, 3'd1, 3'd1, 3'd1};
    rot_w   = '{16'd0, 16'd0, 16'd0, 16'd2, 16'd3, 16'd1};

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_stackOP",   32'(bus.stackOP),   32'd0);
    check("rst_w",         32'(bus.w),         32'd0);
    check("rst_ready",     32'(bus.cmd_ready), 32'd1);
    check("rst_depth",     32'(bus.depth),     32'd0);
    check("rst_err_under", 32'(bus.err_under), 32'd0);
    check("rst_err_over",  32'(bus.err_over),  32'd0);
    reset = 1'b1;

    // Table of single-cycle commands
    for (int i = 0; i < 14; i++) begin
      do_cmd(vecs[i].op, vecs[i].data);
      check($sformatf("vec%0d_stackOP", i), 32'(bus.stackOP), 32'(vecs[i].exp_sop));
      if (vecs[i].chk_w) check($sformatf("vec%0d_w", i), 32'(bus.w), 32'(vecs[i].exp_w));
      check($sformatf("vec%0d_depth", i), 32'(bus.depth), 32'(vecs[i].exp_depth));
      check($sformatf("vec%0d_errs", i), 32'({bus.err_under, bus.err_over}), 32'd0);
      @(negedge CLK);
      #1;
      check($sformatf("vec%0d_top", i), 32'(bus.a), 32'(vecs[i].exp_top));
    end
    @(posedge CLK);
    #1;
    check("idle_stackOP", 32'(bus.stackOP), 32'd0);

    // ROT: 1 2 3 -> top 1, 3, 2
    do_cmd(3'd1, 16'd1);
    do_cmd(3'd1, 16'd2);
    do_cmd(3'd1, 16'd3);
    do_cmd(3'd7, 16'd0);
    low_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.cmd_ready) break;
      check($sformatf("rot%0d_stackOP", k), 32'(bus.stackOP), (k < 6) ? 32'(rot_ops[k]) : 32'd7);
      if (k >= 3 && k < 6) check($sformatf("rot%0d_w", k), 32'(bus.w), 32'(rot_w[k]));
      low_cnt++;
      @(posedge CLK);
      #1;
    end
    check("rot_ready_low_cycles", 32'(low_cnt), 32'd6);
    check("rot_end_stackOP", 32'(bus.stackOP), 32'd0);
    check("rot_depth", 32'(bus.depth), 32'd3);
    @(negedge CLK);
    #1;
    check("rot_s0", 32'(stk[0]), 32'd1);
    check("rot_s1", 32'(stk[1]), 32'd3);
    check("rot_s2", 32'(stk[2]), 32'd2);

    // Asynchronous reset in the middle of a ROT
    do_cmd(3'd7, 16'd0);
    @(posedge CLK);
    #1;
    check("midrot_ready", 32'(bus.cmd_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("async_rst_stackOP", 32'(bus.stackOP),   32'd0);
    check("async_rst_depth",   32'(bus.depth),     32'd0);
    check("async_rst_ready",   32'(bus.cmd_ready), 32'd1);
    @(negedge CLK);
    reset = 1'b1;

    // Back-to-back PUSH 1..4 with cmd_valid held high
    acc = 0;
    for (int i = 1; i <= 4; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd1;
      bus.cmd_data  = 16'(i);
      if (bus.cmd_ready) acc++;
      @(posedge CLK);
      #1;
      check($sformatf("b2b%0d_stackOP", i), 32'(bus.stackOP), 32'd1);
      check($sformatf("b2b%0d_w", i), 32'(bus.w), 32'(i));
      @(negedge CLK);
    end
    bus.cmd_valid = 1'b0;
    #1;
    check("b2b_accepts", 32'(acc), 32'd4);
    check("b2b_depth", 32'(bus.depth), 32'd4);
    check("b2b_top", 32'(bus.a), 32'd4);
    @(posedge CLK);
    #1;
    check("b2b_idle_stackOP", 32'(bus.stackOP), 32'd0);

    // Underflow / overflow boundaries from an empty sequencer
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    do_cmd(3'd2, 16'd0);
`ifdef STACK_SEQ_GUARD_EN
    check("under_stackOP", 32'(bus.stackOP),   32'd0);
    check("under_err",     32'(bus.err_under), 32'd1);
`else
    check("under_stackOP", 32'(bus.stackOP),   32'd3);
    check("under_err",     32'(bus.err_under), 32'd0);
`endif
    check("under_depth", 32'(bus.depth), 32'd0);
    @(posedge CLK);
    #1;
    check("under_err_clear", 32'(bus.err_under), 32'd0);

    for (int i = 0; i < 64; i++) do_cmd(3'd1, 16'(i + 100));
    check("full_depth", 32'(bus.depth), 32'd64);
    do_cmd(3'd1, 16'hBEEF);
`ifdef STACK_SEQ_GUARD_EN
    check("over_stackOP", 32'(bus.stackOP),  32'd0);
    check("over_err",     32'(bus.err_over), 32'd1);
`else
    check("over_stackOP", 32'(bus.stackOP),  32'd1);
    check("over_err",     32'(bus.err_over), 32'd0);
`endif
    check("over_depth", 32'(bus.depth), 32'd64);
    @(posedge CLK);
    #1;
    check("over_err_clear", 32'(bus.err_over), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
